shift_reg_chain_output: RTL and testbench

Serialises a parallel word into a daisy-chain of NUM_DEVICES 74HC595 shift registers. Generates the serial data, shift clock and storage-latch pulse at a programmable, divided bit rate. A valid/ready handshake replaces the single-toggle trigger, and bit order is selectable. Sits between display/LED driver logic and the FPGA pins driving an external '595 chain.

---
 rtl/shift_reg_chain_output.sv | 120 ++++++++++++
 tb/tb_shift_reg_chain_output.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_chain_output.sv
// Serialises a parallel word into a daisy-chain of 74HC595 shift registers,
// generating SER, SRCLK and RCLK at a divided bit rate behind a valid/ready handshake.
module shift_reg_chain_output #(
    parameter int unsigned NUM_DEVICES = 2,
    parameter int unsigned CLK_DIV     = 1,
    parameter bit          LSB_FIRST   = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [8*NUM_DEVICES-1:0] i_value,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic                     o_done,
    output logic                     o_data_val,
    output logic                     o_data_clock,
    output logic                     o_latch_shifted_value
);
    localparam int unsigned N  = 8 * NUM_DEVICES;
    localparam int unsigned BW = $clog2(N + 1);
    localparam int unsigned DW = $clog2(CLK_DIV + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HIGH,
        LATCH
    } state_t;

    state_t        state;
    logic [N-1:0]  shreg;
    logic [N-1:0]  shreg_next;
    logic [BW-1:0] bit_cnt;
    logic [DW-1:0] div_cnt;
    logic          div_last;
    logic          next_bit;
    logic          first_bit;

    assign o_ready  = (state == IDLE);
    assign div_last = (div_cnt == DW'(CLK_DIV - 1));

    // The bit presented next always sits at the outgoing end of the shifted register.
    always_comb begin
        shreg_next = '0;
        next_bit   = 1'b0;
        first_bit  = 1'b0;
        if (LSB_FIRST) begin
            shreg_next = shreg >> 1;
            next_bit   = shreg_next[0];
            first_bit  = i_value[0];
        end else begin
            shreg_next = shreg << 1;
            next_bit   = shreg_next[N-1];
            first_bit  = i_value[N-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state                 <= IDLE;
            shreg                 <= '0;
            bit_cnt               <= '0;
            div_cnt               <= '0;
            o_done                <= 1'b0;
            o_data_val            <= 1'b0;
            o_data_clock          <= 1'b0;
            o_latch_shifted_value <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        shreg      <= i_value;
                        o_data_val <= first_bit;
                        bit_cnt    <= '0;
                        div_cnt    <= '0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_last) begin
                        div_cnt      <= '0;
                        o_data_clock <= 1'b1;
                        state        <= HIGH;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                HIGH: begin
                    if (div_last) begin
                        div_cnt      <= '0;
                        o_data_clock <= 1'b0;
                        bit_cnt      <= bit_cnt + BW'(1);
                        shreg        <= shreg_next;
                        if (bit_cnt == BW'(N - 1)) begin
                            o_data_val            <= 1'b0;
                            o_latch_shifted_value <= 1'b1;
                            state                 <= LATCH;
                        end else begin
                            o_data_val <= next_bit;
                            state      <= SETUP;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                LATCH: begin
                    if (div_last) begin
                        div_cnt               <= '0;
                        o_latch_shifted_value <= 1'b0;
                        o_done                <= 1'b1;
                        state                 <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_reg_chain_output.sv
// Bench for shift_reg_chain_output: four parameterisations, a behavioural '595 chain
// model fed from the serial pins, and a queue of expected latched words.
module tb_shift_reg_chain_output;
    function automatic int unsigned nd_of(input int g);
        case (g)
            0: return 2;
            1: return 2;
            2: return 1;
            default: return 4;
        endcase
    endfunction
    function automatic int unsigned div_of(input int g);
        case (g)
            0: return 1;
            1: return 3;
            2: return 2;
            default: return 5;
        endcase
    endfunction
    function automatic bit lsb_of(input int g);
        return (g == 1 || g == 3);
    endfunction

    logic        clk;
    logic [3:0]  rst_n;
    logic [3:0]  valid;
    logic [31:0] value;
    logic [3:0]  ready, done, dv, dc, lat;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned ND = nd_of(g);
        shift_reg_chain_output #(
            .NUM_DEVICES(ND),
            .CLK_DIV    (div_of(g)),
            .LSB_FIRST  (lsb_of(g))
        ) u_dut (
            .i_clk                (clk),
            .i_reset_n            (rst_n[g]),
            .i_value              (value[8*ND-1:0]),
            .i_valid              (valid[g]),
            .o_ready              (ready[g]),
            .o_done               (done[g]),
            .o_data_val           (dv[g]),
            .o_data_clock         (dc[g]),
            .o_latch_shifted_value(lat[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    int unsigned cur, cur_n, cur_d;
    bit          cur_lsb;
    logic [31:0] mask, chain, store, cur_v;
    int unsigned cyc, abs_cyc, rises, hi_w, lat_w, dones, accepts, lat_pulses;
    int unsigned last_acc_abs, last_done_abs;
    logic        prev_dc, prev_lat, prev_dv;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: dut=%0h expected=%0h (dut %0d, t=%0t)", tag, act, exp, cur, $time);
        end
    endtask

    function automatic logic [31:0] exp_of(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        if (cur_lsb) begin
            for (int i = 0; i < int'(cur_n); i++) r[cur_n-1-i] = v[i];
        end else begin
            r = v & mask;
        end
        return r;
    endfunction

    task automatic use_dut(input int unsigned g);
        cur      = g;
        cur_n    = 8 * nd_of(int'(g));
        cur_d    = div_of(int'(g));
        cur_lsb  = lsb_of(int'(g));
        mask     = (cur_n == 32) ? '1 : ((32'd1 << cur_n) - 32'd1);
        chain    = '0;
        store    = '0;
        prev_dc  = 1'b0;
        prev_lat = 1'b0;
        prev_dv  = 1'b0;
        rises    = 0;
    endtask

    // One clock: scoreboard push on accept, then sample #1 after the edge and update the '595 model.
    task automatic tick();
        bit   acc, rs;
        logic c_dc, c_lat, c_dv, c_done, c_rdy;
        rs  = rst_n[cur];
        acc = valid[cur] && ready[cur] && rs;
        if (acc) begin
            exp_q.push_back(exp_of(value));
            cur_v        = value & mask;
            accepts++;
            last_acc_abs = abs_cyc;
        end
        @(posedge clk);
        #1;
        abs_cyc++;
        cyc = acc ? 1 : cyc + 1;
        if (acc) rises = 0;
        c_dc   = dc[cur];
        c_lat  = lat[cur];
        c_dv   = dv[cur];
        c_done = done[cur];
        c_rdy  = ready[cur];
        if (!rs) check_eq("reset_outputs", 32'({c_rdy, c_done, c_dv, c_dc, c_lat}), 32'h10);
        check_eq("clk_latch_overlap", 32'(c_dc & c_lat), 32'd0);
        if (c_dc && !prev_dc) begin
            check_eq("data_stable_at_rise", 32'(c_dv), 32'(prev_dv));
            if (rises == 0) begin
                check_eq("first_bit", 32'(c_dv), 32'(cur_lsb ? cur_v[0] : cur_v[cur_n-1]));
                check_eq("first_rise_cycle", cyc, cur_d + 1);
            end
            rises++;
            chain = ((chain << 1) | 32'(c_dv)) & mask;
            hi_w  = 0;
        end
        if (c_dc) hi_w++;
        if (!c_dc && prev_dc && rs) check_eq("clock_high_width", hi_w, cur_d);
        if (c_lat && !prev_lat) begin
            store = chain;
            lat_pulses++;
            check_eq("latch_start_cycle", cyc, 2 * cur_n * cur_d + 1);
            lat_w = 0;
        end
        if (c_lat) lat_w++;
        if (!c_lat && prev_lat && rs) check_eq("latch_width", lat_w, cur_d);
        if (c_done) begin
            dones++;
            last_done_abs = abs_cyc;
            check_eq("done_cycle", cyc, (2 * cur_n + 1) * cur_d + 1);
            check_eq("rise_count", rises, cur_n);
            if (exp_q.size() == 0) check_eq("scoreboard_underflow", 32'd1, 32'd0);
            else check_eq("latched_word", store, exp_q.pop_front());
        end
        prev_dc  = c_dc;
        prev_lat = c_lat;
        prev_dv  = c_dv;
    endtask

    task automatic wait_accept();
        int unsigned a0, k;
        a0 = accepts;
        k  = 0;
        while (accepts == a0 && k < 50) begin tick(); k++; end
        valid[cur] = 1'b0;
        check_eq("accept_timeout", 32'(accepts - a0), 32'd1);
    endtask

    task automatic wait_dones(input int unsigned target);
        int unsigned k;
        k = 0;
        while (dones < target && k < 2 * ((2 * cur_n + 1) * cur_d + 1) + 20) begin tick(); k++; end
        check_eq("done_timeout", 32'(dones >= target), 32'd1);
    endtask

    task automatic send(input logic [31:0] v);
        int unsigned d0;
        value      = v;
        valid[cur] = 1'b1;
        d0         = dones;
        wait_accept();
        wait_dones(d0 + 1);
    endtask

    initial begin
        int unsigned a0, d0, k, lp0;
        logic [31:0] saved;
        abs_cyc = 0; cyc = 0; dones = 0; accepts = 0; lat_pulses = 0; hi_w = 0; lat_w = 0;
        last_acc_abs = 0; last_done_abs = 1;
        valid = '0;
        value = '0;
        rst_n = '0;
        use_dut(0);
        repeat (3) tick();
        rst_n = '1;
        tick();

        send(32'h0000_A5C3);
        check_eq("stream_A5C3", store, 32'h0000_A5C3);

        // Back-to-back with a value that changes every cycle.
        valid[0] = 1'b1;
        a0 = accepts;
        d0 = dones;
        k  = 0;
        while (accepts < a0 + 2 && k < 200) begin value = $urandom; tick(); k++; end
        valid[0] = 1'b0;
        check_eq("b2b_accept_in_done_cycle", last_acc_abs, last_done_abs);
        wait_dones(d0 + 2);

        // Reset after the 5th shift-clock rise aborts without latching.
        value    = $urandom;
        valid[0] = 1'b1;
        wait_accept();
        k = 0;
        while (rises < 5 && k < 100) begin tick(); k++; end
        saved = store;
        lp0   = lat_pulses;
        d0    = dones;
        rst_n[0] = 1'b0;
        tick();
        rst_n[0] = 1'b1;
        void'(exp_q.pop_back());
        repeat (40) tick();
        check_eq("abort_no_done", dones - d0, 32'd0);
        check_eq("abort_no_latch", lat_pulses - lp0, 32'd0);
        check_eq("abort_store_kept", store, saved);
        send(32'h0000_3C96);

        use_dut(1);
        send(32'h0000_0001);
        check_eq("lsb_first_0001", store, 32'h0000_8000);
        send($urandom);

        use_dut(2);
        repeat (3) send($urandom);

        use_dut(3);
        repeat (3) send($urandom);

        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
